// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the RV32I pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/sb_match.sv
// ============================================================================
// Module      : sb_match
// Description : Combinational scoreboard search for one source register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_match
  import pipeline_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int SEARCH_N = 3
) (
  input  sb_entry_t [DEPTH-1:0] entries_i,
  input  logic [4:0]            rs_i,
  input  logic                  use_i,
  output logic                  hit_o
);

  // Only the youngest SEARCH_N entries can still collide with an ID read.
  always_comb begin
    hit_o = 1'b0;
    if (use_i && (rs_i != REG_ZERO)) begin
      for (int i = 0; i < SEARCH_N; i++) begin
        if (entries_i[i].valid && (entries_i[i].rd == rs_i)) begin
          hit_o = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module      : hazard_controller
// Description : RAW-stall / redirect-flush / freeze sequencing with perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int DEPTH            = 3,
  parameter int RF_WRITE_THROUGH = 0,
  parameter int FLUSH_CYCLES     = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             ex_redirect,
  input  logic             ext_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_kill,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int         c_SEARCH_N  = DEPTH - RF_WRITE_THROUGH;
  localparam logic [2:0] c_KILL_INIT = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t            state_q, state_d;
  logic [2:0]             kill_q, kill_d;
  sb_entry_t [DEPTH-1:0]  sb_q;
  logic [CNT_W-1:0]       stall_cnt_q, flush_cnt_q;
  logic                   w_stall_inc, w_flush_inc;
  logic                   w_hit_rs1, w_hit_rs2, w_hazard;

  sb_match #(.DEPTH(DEPTH), .SEARCH_N(c_SEARCH_N)) u_match_rs1 (
    .entries_i (sb_q),
    .rs_i      (id_rs1),
    .use_i     (id_use_rs1),
    .hit_o     (w_hit_rs1)
  );

  sb_match #(.DEPTH(DEPTH), .SEARCH_N(c_SEARCH_N)) u_match_rs2 (
    .entries_i (sb_q),
    .rs_i      (id_rs2),
    .use_i     (id_use_rs2),
    .hit_o     (w_hit_rs2)
  );

  assign w_hazard = id_valid && (w_hit_rs1 || w_hit_rs2);

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pipe_en     = 1'b1;
    idex_kill   = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (reset) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_en   = 1'b0;
      idex_kill = 1'b1;
    end else if (ext_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (ex_redirect) begin
      idex_kill   = 1'b1;
      w_flush_inc = 1'b1;
      kill_d      = c_KILL_INIT;
      state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      idex_kill   = 1'b1;
      w_flush_inc = 1'b1;
      kill_d      = kill_q - 3'd1;
      if (kill_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (w_hazard) begin
      // Hold IF and ID, let a bubble advance until the producer retires.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_kill   = 1'b1;
      w_stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      kill_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q <= '0;
    end else if (pipe_en) begin
      sb_q[0].valid <= id_valid && id_reg_write && (id_rd != REG_ZERO) && !idex_kill;
      sb_q[0].rd    <= id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Counters saturate so long runs never appear to reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_stall_inc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (w_flush_inc && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module      : tb_hazard_controller
// Description : Directed self-checking bench for hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, ext_stall;

  logic        pc_en, ifid_en, idex_kill, pipe_en;
  logic [31:0] stall_cnt, flush_cnt;
  logic        wt_pc_en, wt_ifid_en, wt_idex_kill, wt_pipe_en;
  logic [31:0] wt_stall_cnt, wt_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_controller u_dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_kill(idex_kill), .pipe_en(pipe_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_controller #(.RF_WRITE_THROUGH(1)) u_dut_wt (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_en(wt_pc_en), .ifid_en(wt_ifid_en), .idex_kill(wt_idex_kill), .pipe_en(wt_pipe_en),
    .stall_cnt(wt_stall_cnt), .flush_cnt(wt_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic rw);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw;
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    reset = 1'b1; ex_redirect = 1'b0; ext_stall = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_ifid_en", {31'd0, ifid_en}, 32'd0);
    check("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    check("rst_kill", {31'd0, idex_kill}, 32'd1);
    reset = 1'b0;
    tick();
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);

    // Independent instructions back to back.
    for (int i = 1; i <= 5; i++) begin
      set_id(1'b1, 5'(i + 10), 1'b1, 5'(i + 20), 1'b1, 5'(i), 1'b1);
      check($sformatf("indep_pc_en_%0d", i), {31'd0, pc_en}, 32'd1);
      check($sformatf("indep_kill_%0d", i), {31'd0, idex_kill}, 32'd0);
      tick();
    end
    check("indep_stall_cnt", stall_cnt, 32'd0);
    drain();

    // addi x5 ; add x6,x5,x0
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    check("raw_prod_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("raw_pc_en_c%0d", k), {31'd0, pc_en}, (k < 3) ? 32'd0 : 32'd1);
      check($sformatf("raw_kill_c%0d", k), {31'd0, idex_kill}, (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("raw_pipe_en_c%0d", k), {31'd0, pipe_en}, 32'd1);
      check($sformatf("rawwt_pc_en_c%0d", k), {31'd0, wt_pc_en}, (k < 2) ? 32'd0 : 32'd1);
      tick();
    end
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("raw_stall_cnt", stall_cnt, 32'd3);
    check("rawwt_stall_cnt", wt_stall_cnt, 32'd2);
    drain();

    // x0 producer/consumer never stalls.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1);
    check("x0_pc_en", {31'd0, pc_en}, 32'd1);
    check("x0_kill", {31'd0, idex_kill}, 32'd0);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("x0_stall_cnt", stall_cnt, 32'd3);
    drain();

    // Redirect with a pending hazard on x7 that must be ignored.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    ex_redirect = 1'b1; #1;
    check("redir_pc_en", {31'd0, pc_en}, 32'd1);
    check("redir_kill", {31'd0, idex_kill}, 32'd1);
    tick();
    ex_redirect = 1'b0; #1;
    check("flush_pc_en", {31'd0, pc_en}, 32'd1);
    check("flush_kill", {31'd0, idex_kill}, 32'd1);
    tick();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("post_flush_kill", {31'd0, idex_kill}, 32'd0);
    check("redir_flush_cnt", flush_cnt, 32'd2);
    check("redir_stall_cnt", stall_cnt, 32'd3);
    drain();

    // RAW stall interrupted by a 4-cycle ext_stall.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);
    check("frz_pre_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    ext_stall = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("frz_en_c%0d", k), {28'd0, pc_en, ifid_en, pipe_en, idex_kill}, 32'd0);
      tick();
    end
    ext_stall = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("frz_rel_pc_en_c%0d", k), {31'd0, pc_en}, (k < 2) ? 32'd0 : 32'd1);
      tick();
    end
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("frz_stall_cnt", stall_cnt, 32'd6);
    drain();

    // Redirect held across an ext_stall.
    ex_redirect = 1'b1; ext_stall = 1'b1; #1;
    check("rs_frz_pc_en", {31'd0, pc_en}, 32'd0);
    check("rs_frz_kill", {31'd0, idex_kill}, 32'd0);
    tick();
    check("rs_frz_flush_cnt", flush_cnt, 32'd2);
    ext_stall = 1'b0; #1;
    check("rs_rel_pc_en", {31'd0, pc_en}, 32'd1);
    check("rs_rel_kill", {31'd0, idex_kill}, 32'd1);
    tick();
    ex_redirect = 1'b0; #1;
    check("rs_flush_kill", {31'd0, idex_kill}, 32'd1);
    tick();
    check("rs_run_kill", {31'd0, idex_kill}, 32'd0);
    check("rs_flush_cnt", flush_cnt, 32'd4);

    // Reset during FLUSH.
    ex_redirect = 1'b1; #1;
    tick();
    ex_redirect = 1'b0; reset = 1'b1; #1;
    check("rstf_kill", {31'd0, idex_kill}, 32'd1);
    check("rstf_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    reset = 1'b0; #1;
    check("rstf_run_kill", {31'd0, idex_kill}, 32'd0);
    check("rstf_run_pc_en", {31'd0, pc_en}, 32'd1);
    check("rstf_flush_cnt", flush_cnt, 32'd0);
    check("rstf_stall_cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the single-issue RV32I core (IF, ID, EX, MEM, WB).
- The datapath has no forwarding. The register file is read in ID and written in WB.
- This block keeps a destination-register scoreboard that shadows the pipeline stage registers, stalls ID on RAW hazards, squashes wrong-path instructions after an EX redirect (branch/jump), and freezes the whole pipe on an external stall.
- It drives the enable and kill signals that gate the IF/ID and ID/EX stage registers. It also keeps stall and flush performance counters.

Parameters:
- DEPTH, 3, scoreboard entries: instructions in flight downstream of ID. Entry 0 is EX; entry DEPTH-1 is WB.
- RF_WRITE_THROUGH, 0: 1 means the register file forwards a same-cycle write to its reads, so entry DEPTH-1 causes no hazard.
- FLUSH_CYCLES, 2: number of ID kills per redirect, covering the instructions in ID and IF at redirect time. Legal values are 1 to 7.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1 of the ID instruction
- id_rs2  in  5  source register 2 of the ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  5  destination register of the ID instruction
- id_reg_write  in  1  ID instruction writes rd
- ex_redirect  in  1  EX resolved a taken branch or jump (pc_src)
- ext_stall  in  1  memory or other agent requests a whole-pipe freeze
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- idex_kill  out  1  replace the ID instruction with a bubble entering EX
- pipe_en  out  1  enable for the ID/EX, EX/MEM and MEM/WB shift registers
- stall_cnt  out  CNT_W  RAW-stall cycles
- flush_cnt  out  CNT_W  killed wrong-path slots

Behaviour:
- Reset is synchronous and active-high.
  - In reset: pc_en=0, ifid_en=0, idex_kill=1, pipe_en=0.
  - Reset clears the scoreboard (all entries invalid), puts the FSM in RUN, zeroes the flush counter, and zeroes both perf counters.
  - Reset asserted mid-flush or mid-stall abandons that state immediately.
- Scoreboard entry: {valid, rd[4:0]}.
  - When pipe_en=1, each entry shifts one place toward DEPTH-1 every cycle.
  - Entry 0 loads {id_valid & id_reg_write & (id_rd!=0) & ~idex_kill, id_rd}.
  - When pipe_en=0, all entries hold.
- Hazard: id_valid is set, and (id_use_rs1 with rs1!=0 matching a valid entry) or (id_use_rs2 with rs2!=0 matching a valid entry). Only entries 0 to DEPTH-1-RF_WRITE_THROUGH are searched. x0 never causes a hazard.
- FSM states: RUN and FLUSH. A 3-bit kill counter counts the remaining kills.
- Outputs are combinational from state and inputs. Priority from highest: reset, ext_stall, ex_redirect, FLUSH, hazard, normal.
  1. ext_stall=1 freezes everything: pc_en=0, ifid_en=0, pipe_en=0, idex_kill=0. The FSM, kill counter, scoreboard and perf counters hold. The source must keep ex_redirect asserted until the stall releases.
  2. ex_redirect=1 (either state): pc_en=1, ifid_en=1, pipe_en=1, idex_kill=1, flush_cnt += 1. The FSM goes to FLUSH with kill counter = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, the FSM stays in RUN. The hazard check is ignored this cycle.
  3. In FLUSH (no redirect): all enables are 1, idex_kill=1, flush_cnt += 1, kill counter decrements. The FSM returns to RUN when the counter reaches 0. Hazards are ignored because the slot is killed anyway.
  4. Hazard in RUN: pc_en=0, ifid_en=0, pipe_en=1, idex_kill=1, stall_cnt += 1. The bubble shifts in and the stall persists until the matching entry retires.
  5. Normal operation: all enables are 1 and idex_kill=0.
- Load-use needs no special case: with no forwarding, every RAW stalls until WB.
- Perf counters saturate at all-ones; they do not wrap.
- Latency:
  - With DEPTH=3 and RF_WRITE_THROUGH=0, a dependent instruction directly behind its producer stalls 3 cycles.
  - With RF_WRITE_THROUGH=1 it stalls 2 cycles.

Decomposition:
- pipeline_pkg holds:
  - typedef sb_entry_t {logic valid; logic [4:0] rd;}
  - enum ctrl_state_t {RUN, FLUSH}
  - localparam REG_ZERO = 5'd0
- Sub-module sb_match(DEPTH): combinational search of the scoreboard for one source register, instantiated twice (rs1 and rs2).
- The scoreboard shift register itself stays in the top level.

Test Plan:
- Reset, then independent instructions every cycle (rd=1..5, disjoint sources) -> pc_en=1 and idex_kill=0 every cycle; stall_cnt=0.
- addi x5 followed immediately by add x6,x5,x0 (default parameters) -> pc_en=0 and idex_kill=1 for exactly 3 cycles, then the add issues; stall_cnt=3. Rerun with RF_WRITE_THROUGH=1 -> exactly 2 cycles, stall_cnt=2.
- Producer writes x0, consumer reads x0 -> no stall; stall_cnt=0.
- ex_redirect pulse for 1 cycle -> idex_kill=1 for 2 consecutive cycles with pc_en=1; flush_cnt=2. A hazard presented during those cycles -> stall_cnt unchanged.
- ext_stall held 4 cycles during a RAW stall -> all enables 0 and the scoreboard frozen. After release the remaining stall cycles complete; the stall_cnt total equals the no-ext_stall case.
- ex_redirect and ext_stall together, then ext_stall drops with redirect still held -> the redirect takes effect on the release cycle. Separately, reset asserted during FLUSH -> the next cycle is RUN with counters at 0.
